rice_prefix_sequencer: RTL
==========================

# rice_prefix_sequencer

Sequences the leading-one counter over an MSB-first Rice-coded bitstream and emits one decoded symbol (quotient, remainder) per handshake. It buffers incoming words and counts unary prefixes of ones terminated by a zero, carrying runs across word boundaries. It then extracts a fixed K-bit remainder. The block sits between the bitstream fetch stage and downstream symbol consumers in the decoder.

## Interface
- W_IN, 8: input word width, ≥2; the leading-one window width.
- K, 2: remainder bits per symbol, 0..W_IN.
- W_Q, 8: quotient accumulator width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of buffer and symbol state.
- in_data  in  W_IN  bitstream word; bit W_IN-1 is first in stream order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- out_value  out  W_Q+K  {quotient, remainder}.
- out_overflow  out  1  quotient saturated for this symbol.
- out_valid  out  1  symbol valid.
- out_ready  in  1  symbol consumed when out_valid && out_ready.

## Operation
- Buffer: 2*W_IN-bit register, MSB-aligned, fill level 0..2*W_IN. Bits below fill are always zero.
- Accept: in_ready = (fill <= W_IN) && !flush. The word is written at offset (fill − consumed) in the same cycle as any consumption, so new fill = fill − consumed + W_IN.
- Leading-one count: the top W_IN buffer bits feed the codebase count_lead_one unit (W_IN=W_IN), giving n; let v = min(fill, W_IN).
- PREFIX state:
  - fill==0: hold.
  - n < v: terminator found; q_acc += n; consume n+1; go to REM.
  - n == v: all valid bits are ones; q_acc += v; consume v; stay in PREFIX.
- REM state:
  - fill >= K: r = top K bits; consume K; go to EMIT.
  - Otherwise hold.
  - If K==0, PREFIX goes directly to EMIT with r empty.
- EMIT state:
  - out_valid=1; out_value = {q_acc, r}.
  - On out_ready: clear q_acc and ovf; go to PREFIX.
  - No consumption occurs in EMIT; accepting words is still allowed.
- Saturation: if q_acc + increment > 2^W_Q−1, q_acc = 2^W_Q−1 and sticky ovf=1; ovf clears on emit.
- flush: highest priority. fill=0, buffer=0, q_acc=0, ovf=0, state PREFIX, out_valid=0; an offered word is not accepted.
- Reset values: state PREFIX, fill 0, buffer 0, q_acc 0, out_valid 0, out_value 0, out_overflow 0. in_ready is 1 once rst_n is deasserted.

## Timing
- All outputs are registered or derived only from registers; no input→output combinational path except flush gating in_ready.
- One state step per cycle; consumption is at most W_IN bits per cycle.
- Latency: with an empty buffer in PREFIX, a word accepted at edge E0 is processed by PREFIX at E1 and REM at E2. out_valid is high after E2, for a prefix shorter than W_IN with K ≤ remaining bits.
- A prefix of length L costs floor(L/W_IN)+1 PREFIX cycles, given data availability.
- Back-to-back symbols: at most 1 symbol per 3 cycles.
- out_value and out_overflow are held stable while out_valid && !out_ready.
- Reset asserted mid-symbol: all state clears immediately (asynchronously) and the partial symbol is discarded.

## Configuration
- RICE_SEQ_STATS_EN defined:
  - Adds output sym_count [31:0], incremented on each out handshake.
  - Adds output ovf_count [15:0], incremented on handshakes with out_overflow=1.
  - Both wrap; both reset to 0 on rst_n or flush.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- W_IN=8, K=2; word 8'b1110_1100 → value 15 (q=3, r=3), ovf=0. Next word 8'b1000_0000 → value 1 (q=0 from the carried '0', r=2'b01).
- Words 8'hFF, 8'hFF, 8'b0100_0000 → a single symbol, value 66 (q=16, r=2'b10).
- W_Q=4; words 8'hFF, 8'hFF, 8'b0110_0000 → value {4'hF, 2'b11}, out_overflow=1. The next symbol has ovf=0.
- Hold out_ready low for 6 cycles with continuous in_valid: out_value stays stable, in_ready drops once fill > 8, and the full stream decodes correctly afterwards (compare against a model).
- Pulse flush during a 12-one prefix: out_valid=0 and fill=0. The next word 8'b0000_0000 → value 0.
- Assert rst_n low mid-REM: all outputs take their reset values and in_ready=1 after release. With RICE_SEQ_STATS_EN, sym_count=0.

Source files
------------

// File: rtl/rice_prefix_sequencer.sv
// Rice prefix sequencer: counts unary prefixes over an MSB-first word stream and
// emits {quotient, remainder} symbols. Define RICE_SEQ_STATS_EN for handshake counters.

module count_lead_one #(
    parameter int W_IN = 8,
    localparam int CW = $clog2(W_IN + 1)
) (
    input  logic [W_IN-1:0] data,
    output logic [CW-1:0]   count
);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        count = '0;
        for (int i = W_IN - 1; i >= 0; i--) begin
            if (data[i] && (count == CW'(W_IN - 1 - i))) begin
                count = count + 1'b1;
            end
        end
    end

endmodule

module rice_prefix_sequencer #(
    parameter int W_IN = 8,
    parameter int K    = 2,
    parameter int W_Q  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [W_IN-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [W_Q+K-1:0]   out_value,
    output logic               out_overflow,
    output logic               out_valid,
    input  logic               out_ready
`ifdef RICE_SEQ_STATS_EN
    ,
    output logic [31:0]        sym_count,
    output logic [15:0]        ovf_count
`endif
);

    localparam int BW = 2 * W_IN;
    localparam int FW = $clog2(BW + 1);
    localparam int CW = $clog2(W_IN + 1);
    localparam int KW = (K > 0) ? K : 1;
    localparam int SW = ((W_Q > CW) ? W_Q : CW) + 1;
    localparam logic [W_Q-1:0] Q_MAX = '1;

    typedef enum logic [1:0] {
        ST_PREFIX,
        ST_REM,
        ST_EMIT
    } state_e;

    state_e         state_q, state_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [W_Q-1:0] q_acc_q, q_acc_d;
    logic           ovf_q, ovf_d;
    logic [KW-1:0]  rem_q, rem_d;

    logic [CW-1:0]  lead_n;
    logic [FW-1:0]  valid_bits;
    logic [FW-1:0]  consume;
    logic [FW-1:0]  fill_left;
    logic [CW-1:0]  q_inc;
    logic           q_add;
    logic [SW-1:0]  q_sum;
    logic           accept;
    logic [BW-1:0]  buf_shift;
    logic [BW-1:0]  word_placed;

    count_lead_one #(.W_IN(W_IN)) u_clo (
        .data  (buf_q[BW-1 -: W_IN]),
        .count (lead_n)
    );

    assign in_ready   = (fill_q <= FW'(W_IN)) && !flush;
    assign accept     = in_valid && in_ready;
    assign valid_bits = (fill_q < FW'(W_IN)) ? fill_q : FW'(W_IN);

    always_comb begin
        state_d = state_q;
        consume = '0;
        q_inc   = '0;
        q_add   = 1'b0;
        rem_d   = rem_q;
        case (state_q)
            ST_PREFIX: begin
                if (fill_q != '0) begin
                    q_add = 1'b1;
                    // Zeros below fill guarantee lead_n <= valid_bits.
                    if (FW'(lead_n) < valid_bits) begin
                        q_inc   = lead_n;
                        consume = FW'(lead_n) + FW'(1);
                        state_d = (K == 0) ? ST_EMIT : ST_REM;
                    end else begin
                        q_inc   = CW'(valid_bits);
                        consume = valid_bits;
                    end
                end
            end
            ST_REM: begin
                if (fill_q >= FW'(K)) begin
                    rem_d   = buf_q[BW-1 -: KW];
                    consume = FW'(K);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_d = ST_PREFIX;
                end
            end
            default: state_d = ST_PREFIX;
        endcase
    end

    always_comb begin
        q_acc_d = q_acc_q;
        ovf_d   = ovf_q;
        q_sum   = SW'(q_acc_q) + SW'(q_inc);
        if (state_q == ST_EMIT && out_ready) begin
            q_acc_d = '0;
            ovf_d   = 1'b0;
        end else if (q_add) begin
            if (q_sum > SW'(Q_MAX)) begin
                q_acc_d = Q_MAX;
                ovf_d   = 1'b1;
            end else begin
                q_acc_d = q_sum[W_Q-1:0];
            end
        end
    end

    // The incoming word lands directly behind whatever survives this cycle's consumption.
    always_comb begin
        buf_shift   = buf_q << consume;
        fill_left   = fill_q - consume;
        word_placed = {in_data, {W_IN{1'b0}}} >> fill_left;
        buf_d       = accept ? (buf_shift | word_placed) : buf_shift;
        fill_d      = accept ? (fill_left + FW'(W_IN)) : fill_left;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= ST_PREFIX;
            buf_q   <= '0;
            fill_q  <= '0;
            q_acc_q <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else if (flush) begin
            state_q <= ST_PREFIX;
            buf_q   <= '0;
            fill_q  <= '0;
            q_acc_q <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            q_acc_q <= q_acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    assign out_valid    = (state_q == ST_EMIT);
    assign out_overflow = ovf_q;

    generate
        if (K > 0) begin : g_rem
            assign out_value = {q_acc_q, rem_q};
        end else begin : g_no_rem
            assign out_value = q_acc_q;
        end
    endgenerate

`ifdef RICE_SEQ_STATS_EN
    logic [31:0] sym_count_q;
    logic [15:0] ovf_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_count_q <= '0;
            ovf_count_q <= '0;
        end else if (flush) begin
            sym_count_q <= '0;
            ovf_count_q <= '0;
        end else if (out_valid && out_ready) begin
            sym_count_q <= sym_count_q + 32'd1;
            if (ovf_q) begin
                ovf_count_q <= ovf_count_q + 16'd1;
            end
        end
    end

    assign sym_count = sym_count_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule
